usb_sync_eop_detector: RTL and testbench

Parametrised receive-framing block for the USB PHY. It hunts for the SYNC field on the decoded line state, tolerates lost leading SYNC symbols, and tracks the packet body until a valid EOP (SE0 run then J). It flags framing errors and babble, and reports the packet length. It sits between the line-state sampler and the NRZI decoder/bit-unstuffer, and replaces the fixed 8-symbol sync matcher.

---
 rtl/usb_sync_eop_detector.sv | 216 +++++++++++++++++++++
 tb/tb_usb_sync_eop_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_sync_eop_detector.sv
// usb_sync_eop_detector
//   Receive-framing block for the USB PHY. Hunts for SYNC on the decoded line
//   state (tolerating up to SYNC_TOL lost leading symbols), tracks the packet
//   body until a valid EOP (SE0 run followed by J), flags framing errors,
//   SE1 and babble, and reports the body length in samples.
//
//   Optional build macro: USB_BUS_RESET_DET_EN
//     Defined   : BUS_RESET_SAMPLES consecutive SE0 samples raise bus_reset,
//                 force the FSM to IDLE (rx_error if a packet was in progress);
//                 bus_reset clears on the next J sample.
//     Undefined : bus_reset is tied low.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   sample_en     in   one-cycle strobe per bit time; line_state used only then
//   line_state    in   2'b00 SE0, 2'b01 J, 2'b10 K, 2'b11 SE1
//   sync_detected out  pulse, SYNC accepted
//   in_packet     out  level, from SYNC accept until EOP or error
//   eop_detected  out  pulse, valid EOP
//   rx_error      out  pulse, framing error / SE1 / babble
//   pkt_bits      out  body samples (excl. SYNC and EOP), held until next SYNC
//   bus_reset     out  level, bus reset detected (optional feature)
module usb_sync_eop_detector #(
  parameter int unsigned SYNC_LEN          = 8,
  parameter int unsigned SYNC_TOL          = 2,
  parameter int unsigned EOP_SE0_MIN       = 2,
  parameter int unsigned MAX_PKT_BITS      = 1024,
  parameter int unsigned CNT_W             = 11,
  parameter int unsigned BUS_RESET_SAMPLES = 2500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [1:0]       line_state,
  output logic             sync_detected,
  output logic             in_packet,
  output logic             eop_detected,
  output logic             rx_error,
  output logic [CNT_W-1:0] pkt_bits,
  output logic             bus_reset
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam int unsigned ALT_W = $clog2(SYNC_LEN + 1);
  localparam int unsigned SE0_W = $clog2(EOP_SE0_MIN + 1);

  localparam logic [ALT_W-1:0] ALT_MAX = ALT_W'(SYNC_LEN);
  localparam logic [ALT_W-1:0] ALT_THR = ALT_W'(SYNC_LEN - 1 - SYNC_TOL);
  localparam logic [SE0_W-1:0] SE0_MIN = SE0_W'(EOP_SE0_MIN);
  localparam logic [CNT_W-1:0] BITS_MAX = CNT_W'(MAX_PKT_BITS);

  typedef enum logic [1:0] {IDLE, HUNT, PACKET, EOP_WAIT} state_t;

  state_t           state, state_n;
  logic [ALT_W-1:0] alt_cnt, alt_n, alt_inc;
  logic             last_k, last_k_n;
  logic [SE0_W-1:0] se0_cnt, se0_n;
  logic [CNT_W-1:0] bits_n;
  logic             sync_n, eop_n, err_n, in_packet_n;
  logic             br_hit;

`ifdef USB_BUS_RESET_DET_EN
  localparam int unsigned BR_W = $clog2(BUS_RESET_SAMPLES + 1);
  localparam logic [BR_W-1:0] BR_MAX = BR_W'(BUS_RESET_SAMPLES);
  localparam logic [BR_W-1:0] BR_HIT = BR_W'(BUS_RESET_SAMPLES - 1);

  logic [BR_W-1:0] br_cnt;

  // Fires once per SE0 run: the counter saturates past the trigger value.
  assign br_hit = sample_en && (line_state == LS_SE0) && (br_cnt == BR_HIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt    <= '0;
      bus_reset <= 1'b0;
    end else if (sample_en) begin
      if (line_state == LS_SE0) begin
        if (br_cnt != BR_MAX) br_cnt <= br_cnt + BR_W'(1);
      end else begin
        br_cnt <= '0;
      end
      if (br_hit)                  bus_reset <= 1'b1;
      else if (line_state == LS_J) bus_reset <= 1'b0;
    end
  end
`else
  assign br_hit    = 1'b0;
  assign bus_reset = 1'b0;
`endif

  assign alt_inc = (alt_cnt == ALT_MAX) ? alt_cnt : alt_cnt + ALT_W'(1);

  always_comb begin
    state_n  = state;
    alt_n    = alt_cnt;
    last_k_n = last_k;
    se0_n    = se0_cnt;
    bits_n   = pkt_bits;
    sync_n   = 1'b0;
    eop_n    = 1'b0;
    err_n    = 1'b0;
    if (sample_en) begin
      unique case (state)
        IDLE: begin
          if (line_state == LS_K) begin
            state_n  = HUNT;
            alt_n    = ALT_W'(1);
            last_k_n = 1'b1;
          end
        end
        HUNT: begin
          case (line_state)
            LS_J: begin
              if (last_k) begin
                alt_n    = alt_inc;
                last_k_n = 1'b0;
              end else begin
                state_n = IDLE;
              end
            end
            LS_K: begin
              if (!last_k) begin
                alt_n    = alt_inc;
                last_k_n = 1'b1;
              end else if (alt_cnt >= ALT_THR) begin
                state_n = PACKET;
                sync_n  = 1'b1;
                bits_n  = '0;
                se0_n   = '0;
              end else begin
                // KK too early: treat the second K as the start of a new run.
                alt_n = ALT_W'(1);
              end
            end
            LS_SE0:  state_n = IDLE;
            default: begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          endcase
        end
        PACKET: begin
          case (line_state)
            LS_SE0: begin
              se0_n = se0_cnt + SE0_W'(1);
              if (se0_n >= SE0_MIN) state_n = EOP_WAIT;
            end
            LS_SE1: begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
            default: begin
              if (se0_cnt != '0 || pkt_bits == BITS_MAX) begin
                // Short SE0 glitch or babble; pkt_bits keeps its saturated value.
                state_n = IDLE;
                err_n   = 1'b1;
              end else begin
                bits_n = pkt_bits + CNT_W'(1);
              end
            end
          endcase
        end
        EOP_WAIT: begin
          case (line_state)
            LS_SE0: state_n = EOP_WAIT;
            LS_J: begin
              state_n = IDLE;
              eop_n   = 1'b1;
            end
            default: begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          endcase
        end
      endcase
      if (br_hit) begin
        state_n = IDLE;
        sync_n  = 1'b0;
        eop_n   = 1'b0;
        err_n   = (state == PACKET) || (state == EOP_WAIT);
      end
    end
    in_packet_n = (state_n == PACKET) || (state_n == EOP_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      alt_cnt       <= '0;
      last_k        <= 1'b0;
      se0_cnt       <= '0;
      pkt_bits      <= '0;
      sync_detected <= 1'b0;
      eop_detected  <= 1'b0;
      rx_error      <= 1'b0;
      in_packet     <= 1'b0;
    end else begin
      state         <= state_n;
      alt_cnt       <= alt_n;
      last_k        <= last_k_n;
      se0_cnt       <= se0_n;
      pkt_bits      <= bits_n;
      sync_detected <= sync_n;
      eop_detected  <= eop_n;
      rx_error      <= err_n;
      in_packet     <= in_packet_n;
    end
  end

endmodule

// File: tb/tb_usb_sync_eop_detector.sv
// Testbench for usb_sync_eop_detector: directed scenarios plus randomized
// frames, compared sample-by-sample against a behavioural model.
module tb_usb_sync_eop_detector;

  localparam int unsigned SYNC_LEN = 8;
  localparam int unsigned SYNC_TOL = 2;
  localparam int unsigned EOP_MIN  = 2;
  localparam int unsigned MAX_BITS = 20;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned BR_SAMP  = 50;
  localparam int unsigned THR      = SYNC_LEN - 1 - SYNC_TOL;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_en = 1'b0;
  logic [1:0]       line_state = J;
  logic             sync_detected, in_packet, eop_detected, rx_error, bus_reset;
  logic [CNT_W-1:0] pkt_bits;

  usb_sync_eop_detector #(
    .SYNC_LEN(SYNC_LEN), .SYNC_TOL(SYNC_TOL), .EOP_SE0_MIN(EOP_MIN),
    .MAX_PKT_BITS(MAX_BITS), .CNT_W(CNT_W), .BUS_RESET_SAMPLES(BR_SAMP)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .line_state(line_state),
    .sync_detected(sync_detected), .in_packet(in_packet),
    .eop_detected(eop_detected), .rx_error(rx_error),
    .pkt_bits(pkt_bits), .bus_reset(bus_reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: hunt history kept as a queue of symbols since the
  // current alternating run began; body tracked by count and trailing SE0 run.
  logic [1:0] hq[$];
  bit m_hunt, m_pkt, m_br;
  int m_bits, m_se0run, m_brrun;
  bit e_sync, e_eop, e_err;

  task automatic model_reset();
    hq.delete();
    m_hunt = 0; m_pkt = 0; m_br = 0;
    m_bits = 0; m_se0run = 0; m_brrun = 0;
    e_sync = 0; e_eop = 0; e_err = 0;
  endtask

  task automatic model_step(input logic [1:0] s);
    bit was_pkt;
    was_pkt = m_pkt;
    e_sync = 0; e_eop = 0; e_err = 0;
    if (m_pkt) begin
      if (s == SE1) begin e_err = 1; m_pkt = 0; end
      else if (s == SE0) m_se0run++;
      else if (m_se0run >= EOP_MIN) begin
        if (s == J) e_eop = 1; else e_err = 1;
        m_pkt = 0;
      end
      else if (m_se0run > 0) begin e_err = 1; m_pkt = 0; end
      else if (m_bits == MAX_BITS) begin e_err = 1; m_pkt = 0; end
      else m_bits++;
    end else if (m_hunt) begin
      if (s == SE1) begin e_err = 1; m_hunt = 0; end
      else if (s == SE0) m_hunt = 0;
      else if (s != hq[$]) hq.push_back(s);
      else if (s == J) m_hunt = 0;
      else if (hq.size() >= THR) begin
        e_sync = 1; m_hunt = 0; m_pkt = 1; m_bits = 0; m_se0run = 0;
      end else begin
        hq.delete(); hq.push_back(K);
      end
    end else if (s == K) begin
      m_hunt = 1; hq.delete(); hq.push_back(K);
    end
`ifdef USB_BUS_RESET_DET_EN
    if (s == SE0) m_brrun++; else m_brrun = 0;
    if (m_brrun == BR_SAMP) begin
      e_sync = 0; e_eop = 0; e_err = was_pkt;
      m_pkt = 0; m_hunt = 0; m_br = 1;
    end
    if (s == J) m_br = 0;
`else
    if (was_pkt && m_brrun < 0) m_br = 0;
`endif
  endtask

  task automatic check_outputs(input bit pulses_expected);
    check_eq("sync_detected", sync_detected, pulses_expected ? e_sync : 1'b0);
    check_eq("eop_detected",  eop_detected,  pulses_expected ? e_eop  : 1'b0);
    check_eq("rx_error",      rx_error,      pulses_expected ? e_err  : 1'b0);
    check_eq("in_packet",     in_packet,     m_pkt);
    check_eq("pkt_bits",      pkt_bits,      m_bits);
    check_eq("bus_reset",     bus_reset,     m_br);
  endtask

  task automatic send(input logic [1:0] s);
    @(negedge clk);
    sample_en  = 1'b1;
    line_state = s;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    model_step(s);
    check_outputs(1'b1);
  endtask

  // Cycles without a sample strobe: line wiggles, nothing may change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_en  = 1'b0;
      line_state = 2'($urandom);
      @(posedge clk);
      #1;
      check_outputs(1'b0);
    end
  endtask

  // n alternating symbols ending in K, then the closing K.
  task automatic send_sync(input int n);
    for (int i = 0; i < n; i++) send(((n - 1 - i) % 2 == 0) ? K : J);
    send(K);
  endtask

  task automatic send_body(input int n);
    for (int i = 0; i < n; i++) send($urandom_range(0, 1) ? J : K);
  endtask

  initial begin
    model_reset();
    #2;
    check_eq("reset_sync", sync_detected, 0);
    check_eq("reset_inpkt", in_packet, 0);
    check_eq("reset_bits", pkt_bits, 0);
    check_eq("reset_err", rx_error, 0);
    @(negedge clk);
    reset = 1'b0;

    // Full SYNC after idle J, 16-sample body, EOP.
    send(J);
    send_sync(7);
    check_eq("full_sync_pulse", sync_detected, 1);
    send_body(16);
    send(SE0); send(SE0); send(J);
    check_eq("full_eop_pulse", eop_detected, 1);
    check_eq("full_bits", pkt_bits, 16);

    // Truncated SYNC accepted; short SYNC restarts the run.
    idle(2);
    send_sync(5);
    check_eq("trunc_sync_pulse", sync_detected, 1);
    send_body(3); send(SE0); send(SE0); send(J);
    send_sync(3);
    check_eq("short_no_sync", sync_detected, 0);
    check_eq("short_no_pkt", in_packet, 0);
    send(J); send(K); send(J); send(K); send(K);
    check_eq("restart_sync", sync_detected, 1);

    // Single SE0 then K inside body; SE1 while hunting.
    send_body(4); send(SE0); send(K);
    check_eq("se0k_err", rx_error, 1);
    send(K); send(J); send(SE1);
    check_eq("hunt_se1_err", rx_error, 1);

    // Babble: 21 body samples with MAX_PKT_BITS=20.
    send(J); send_sync(7); send_body(21);
    check_eq("babble_err", rx_error, 1);
    check_eq("babble_bits", pkt_bits, MAX_BITS);

    // Strobe gap in the middle of SYNC.
    send(J); send(K); send(J); send(K);
    idle(10);
    send(J); send(K); send(J); send(K); send(K);
    check_eq("gap_sync", sync_detected, 1);

    // Asynchronous reset mid-packet.
    send_body(5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_inpkt", in_packet, 0);
    check_eq("arst_bits", pkt_bits, 0);
    check_eq("arst_err", rx_error, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(3);

`ifdef USB_BUS_RESET_DET_EN
    send(J); send_sync(7); send_body(4);
    for (int i = 0; i < int'(BR_SAMP); i++) send(SE0);
    check_eq("br_level", bus_reset, 1);
    check_eq("br_err", rx_error, 1);
    send(K);
    check_eq("br_hold_k", bus_reset, 1);
    send(J);
    check_eq("br_clear", bus_reset, 0);
`else
    send(J); send_sync(7); send_body(2);
    for (int i = 0; i < 60; i++) send(SE0);
    check_eq("no_br", bus_reset, 0);
    check_eq("eopwait_hold", in_packet, 1);
    send(J);
`endif

    // Randomized frames and junk.
    for (int f = 0; f < 300; f++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) send(2'($urandom));
      end else begin
        logic [1:0] tail;
        send(J);
        send_sync($urandom_range(1, 9));
        send_body($urandom_range(0, 24));
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) send(SE0);
        case ($urandom_range(0, 4))
          0:       tail = K;
          1:       tail = SE1;
          default: tail = J;
        endcase
        send(tail);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
